mem_port_dual_sync: RTL and testbench
=====================================

Name: mem_port_dual_sync

Overview:
- Synchronous, parametrised successor to the combinational dual-port simulation memory.
- Port A is read-only (instruction fetch). Port B is read/write (load/store) with true byte-lane writes driven by size and address offset.
- Both ports use a valid/ready request handshake and a fixed-latency response pipeline. An optional clear FSM zeroes the array after reset.
- Sits between the multi-cycle core's IFU/LSU and the simulation environment.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be 64 (8 byte lanes).
- ADDR_WIDTH, 64, request address width.
- DEPTH, 4096, number of words.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- RD_LATENCY, 1, cycles from request accept to response; legal range 1..4.
- CLEAR_ON_RESET, 0, 1 = zero the whole array after reset before accepting requests.
- INIT_FILE, "", hex image loaded at time 0 when non-empty.

Ports:
- iClock  in  1  clock, rising edge
- iReset  in  1  asynchronous, active-high reset
- iAValid  in  1  port A read request
- oAReady  out  1  port A can accept
- iAAddr  in  ADDR_WIDTH  port A byte address
- oARspValid  out  1  port A response valid
- oARspData  out  DATA_WIDTH  port A read word
- oARspErr  out  1  port A out-of-range
- iBValid  in  1  port B request
- oBReady  out  1  port B can accept
- iBWe  in  1  1 = write, 0 = read
- iBSize  in  2  0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B
- iBAddr  in  ADDR_WIDTH  port B byte address
- iBWrData  in  DATA_WIDTH  write data, LSB-justified
- oBRspValid  out  1  port B response (read data or write ack)
- oBRspData  out  DATA_WIDTH  read word (0 for writes/errors)
- oBRspErr  out  1  out-of-range or misaligned

Behaviour:
- Reset: all oRsp* outputs 0. oAReady = oBReady = 0 while iReset is high. Pipeline valids clear asynchronously. Array contents are not reset.
- FSM states: CLEAR, RUN.
  - Deasserting reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
  - CLEAR writes 0 to one word per cycle, counter 0..DEPTH-1, with both ready outputs low. After the last word (DEPTH cycles) it moves to RUN.
  - Reset asserted mid-CLEAR aborts the sweep; the counter restarts at 0 on the next release.
- RUN: oAReady = oBReady = 1. A request is accepted on a clock edge when valid and ready are both high.
- Index = (addr - BASE_ADDR) >> 3, offset = addr[2:0]. In range iff addr >= BASE_ADDR and index < DEPTH; compute the subtraction at full ADDR_WIDTH with no wrap.
- Port A read:
  - Word sampled at the accept edge.
  - Response appears exactly RD_LATENCY cycles later, one cycle wide.
  - Out of range: data 0, err 1.
- Port B misalignment: offset must be a multiple of (1 << iBSize), otherwise err 1 and no array change.
- Port B write:
  - Byte mask = ((1 << (1 << size)) - 1) << offset.
  - Lane data = iBWrData << (8*offset).
  - Only masked lanes are updated, at the accept edge.
  - Ack response after RD_LATENCY with data 0.
- Port B read: returns the full aligned word; the LSU extracts and extends. Same latency and error rules as port A. Size and alignment are also checked on reads.
- Same-cycle A read and B write to the same word: A returns the old data (read-before-write). A B read in the next cycle returns the new data.
- Back-to-back throughput: one request per port per cycle. Responses carry no backpressure; the consumer must always accept them.
- Errors never block the pipeline.

Decomposition:
- Shared package/Config.v: BYT size codes, BASE_ADDR default, and the lane-mask function (size, offset -> 8-bit mask).
- One natural sub-module, mem_rsp_pipe: a RD_LATENCY-deep shift pipeline of {valid, data, err}, instantiated once per port.
- The array, CLEAR FSM and decode stay in the top module.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16: release reset -> ready low exactly 16 cycles. A read at 0x8000_0078 then returns 0, err 0.
- B write size 3 of 0x1122334455667788 at 0x8000_0010, then A read of the same address -> data 0x1122334455667788 after RD_LATENCY cycles.
- B write size 0 of 0xAB at 0x8000_0013, then B read of 0x8000_0010 -> 0x11223344AB667788.
- B write size 2 at 0x8000_0012 -> err 1, word unchanged. A read at 0x7FFF_FFF8 -> err 1, data 0.
- RD_LATENCY=3, A reads issued on 5 consecutive cycles -> 5 consecutive responses starting 3 cycles after the first accept, in order.
- Reset pulse mid-CLEAR at counter 7 -> all response valids drop immediately; after release, ready stays low for the full DEPTH cycles.

Source files
------------

// File: rtl/mem_port_dual_sync_pkg.sv
// Shared definitions for the dual-port synchronous simulation memory.
//   byt_e             : port B access size codes (1/2/4/8 bytes)
//   state_e           : sequencing states of the clear FSM
//   BASE_ADDR_DEFAULT : byte address of word 0 unless overridden
//   lane_mask()       : (size, offset) -> byte-lane write enables
//   misaligned()      : offset is not a multiple of the access size
package mem_port_dual_sync_pkg;

  typedef enum logic [1:0] {
    BYT_1 = 2'd0,
    BYT_2 = 2'd1,
    BYT_4 = 2'd2,
    BYT_8 = 2'd3
  } byt_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [63:0] BASE_ADDR_DEFAULT = 64'h8000_0000;

  // Built 16 bits wide so an 8-byte access (0xFF) cannot overflow before truncation.
  function automatic logic [7:0] lane_mask(input byt_e size, input logic [2:0] offset);
    logic [15:0] ones;
    ones = (16'd1 << (5'd1 << size)) - 16'd1;
    return 8'(ones << offset);
  endfunction

  function automatic logic misaligned(input byt_e size, input logic [2:0] offset);
    logic [3:0] nbytes;
    nbytes = 4'd1 << size;
    return (({1'b0, offset} & (nbytes - 4'd1)) != 4'd0);
  endfunction

endpackage

// File: rtl/mem_port_dual_sync_if.sv
// Request/response bundle between the core (IFU on port A, LSU on port B)
// and the memory.
//   a_valid/a_ready/a_addr             : port A read request handshake
//   a_rsp_valid/a_rsp_data/a_rsp_err   : port A response (no backpressure)
//   b_valid/b_ready/b_we/b_size/b_addr/b_wr_data : port B request handshake
//   b_rsp_valid/b_rsp_data/b_rsp_err   : port B response (read data or write ack)
// master = core side, slave = memory side.
interface mem_port_dual_sync_if
  import mem_port_dual_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_rsp_valid;
  logic [DATA_WIDTH-1:0] a_rsp_data;
  logic                  a_rsp_err;

  logic                  b_valid;
  logic                  b_ready;
  logic                  b_we;
  byt_e                  b_size;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wr_data;
  logic                  b_rsp_valid;
  logic [DATA_WIDTH-1:0] b_rsp_data;
  logic                  b_rsp_err;

  modport master (
    output a_valid, a_addr, b_valid, b_we, b_size, b_addr, b_wr_data,
    input  a_ready, a_rsp_valid, a_rsp_data, a_rsp_err,
    input  b_ready, b_rsp_valid, b_rsp_data, b_rsp_err
  );

  modport slave (
    input  a_valid, a_addr, b_valid, b_we, b_size, b_addr, b_wr_data,
    output a_ready, a_rsp_valid, a_rsp_data, a_rsp_err,
    output b_ready, b_rsp_valid, b_rsp_data, b_rsp_err
  );
endinterface

// File: rtl/mem_port_dual_sync_rsp_pipe.sv
// mem_rsp_pipe: fixed-latency response shift pipeline of {valid, data, err}.
// A value presented on in_* at a clock edge appears on out_* LATENCY edges
// later (LATENCY registers). Every stage clears asynchronously on rst.
//   clk, rst                     : clock, async active-high reset
//   in_valid, in_data, in_err    : response captured at the accept edge
//   out_valid, out_data, out_err : delayed response
module mem_rsp_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_err,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);
  logic [LATENCY-1:0]    vld_q;
  logic [LATENCY-1:0]    err_q;
  logic [DATA_WIDTH-1:0] dat_q [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      err_q[0] <= in_err;
      dat_q[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];
endmodule

// File: rtl/mem_port_dual_sync.sv
// Synchronous dual-port simulation memory for the multi-cycle core.
// Port A: read-only (instruction fetch). Port B: read/write with byte-lane
// writes selected by size and address offset. Both ports accept one request
// per cycle and respond exactly RD_LATENCY cycles after the accept edge.
// DATA_WIDTH must be 64 (8 byte lanes); DEPTH must be at least 2.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (array contents are kept)
//   bus  : request/response bundle, slave side
//
// state    | meaning
// ST_CLEAR | zeroing one word per cycle, both ports not ready
// ST_RUN   | both ports ready, requests accepted on valid && ready
module mem_port_dual_sync
  import mem_port_dual_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 64,
  parameter int                    ADDR_WIDTH     = 64,
  parameter int                    DEPTH          = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(BASE_ADDR_DEFAULT),
  parameter int                    RD_LATENCY     = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b0,
  parameter string                 INIT_FILE      = ""
) (
  input logic                clk,
  input logic                rst,
  mem_port_dual_sync_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- clear FSM ----------------
  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q;
  logic             clr_last;
  logic             clr_we;
  logic             rdy;

  assign clr_last = (clr_cnt_q == IDX_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_last) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // rst is folded in so ready drops the moment reset asserts, not at the next edge.
  always_comb begin
    rdy    = 1'b0;
    clr_we = 1'b0;
    case (state_q)
      ST_CLEAR: clr_we = ~rst;
      ST_RUN:   rdy    = ~rst;
      default:  ;
    endcase
  end

  // Restarts from word 0 on every reset, so an aborted sweep is redone in full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         clr_cnt_q <= '0;
    else if (clr_we) clr_cnt_q <= clr_last ? '0 : clr_cnt_q + IDX_W'(1);
  end

  assign bus.a_ready = rdy;
  assign bus.b_ready = rdy;

  // ---------------- address decode ----------------
  // Range test needs addr >= BASE_ADDR explicitly: the subtraction alone wraps.
  logic [ADDR_WIDTH-1:0] a_rel, b_rel;
  logic                  a_in_range, b_in_range;
  logic [IDX_W-1:0]      a_idx, b_idx;
  logic [2:0]            b_off;

  assign a_rel      = bus.a_addr - BASE_ADDR;
  assign b_rel      = bus.b_addr - BASE_ADDR;
  assign a_in_range = (bus.a_addr >= BASE_ADDR) && ((a_rel >> 3) < ADDR_WIDTH'(DEPTH));
  assign b_in_range = (bus.b_addr >= BASE_ADDR) && ((b_rel >> 3) < ADDR_WIDTH'(DEPTH));
  assign a_idx      = a_rel[IDX_W+2:3];
  assign b_idx      = b_rel[IDX_W+2:3];
  assign b_off      = bus.b_addr[2:0];

  logic                  a_acc, b_acc, b_err, b_wr;
  logic [LANES-1:0]      b_mask;
  logic [DATA_WIDTH-1:0] b_lane_data;

  assign a_acc       = bus.a_valid & rdy;
  assign b_acc       = bus.b_valid & rdy;
  assign b_err       = ~b_in_range | misaligned(bus.b_size, b_off);
  assign b_wr        = b_acc & bus.b_we & ~b_err;
  assign b_mask      = lane_mask(bus.b_size, b_off);
  assign b_lane_data = bus.b_wr_data << {b_off, 3'b000};

  // ---------------- array ----------------
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (b_wr) begin
      for (int i = 0; i < LANES; i++)
        if (b_mask[i]) mem[b_idx][8*i +: 8] <= b_lane_data[8*i +: 8];
    end
  end

  // Reads sample the array before this edge's write lands: read-before-write.
  logic [DATA_WIDTH-1:0] a_rd, b_rd;
  assign a_rd = (a_acc && a_in_range)          ? mem[a_idx] : '0;
  assign b_rd = (b_acc && !bus.b_we && !b_err) ? mem[b_idx] : '0;

  mem_rsp_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(RD_LATENCY)) u_a_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_acc),
    .in_data   (a_rd),
    .in_err    (a_acc & ~a_in_range),
    .out_valid (bus.a_rsp_valid),
    .out_data  (bus.a_rsp_data),
    .out_err   (bus.a_rsp_err)
  );

  mem_rsp_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(RD_LATENCY)) u_b_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_acc),
    .in_data   (b_rd),
    .in_err    (b_acc & b_err),
    .out_valid (bus.b_rsp_valid),
    .out_data  (bus.b_rsp_data),
    .out_err   (bus.b_rsp_err)
  );
endmodule

// File: tb/tb_mem_port_dual_sync.sv
module tb_mem_port_dual_sync;
  import mem_port_dual_sync_pkg::*;

  localparam int          LAT   = 3;
  localparam int          DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_dual_sync_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) bus ();

  mem_port_dual_sync #(
    .DATA_WIDTH(64), .ADDR_WIDTH(64), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .RD_LATENCY(LAT), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        xa, xb;
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [63:0] mdl [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (((a - BASE) >> 3) < 64'(DEPTH));
  endfunction

  function automatic int widx(input logic [63:0] a);
    logic [63:0] r;
    r = (a - BASE) >> 3;
    return int'(r);
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (bus.a_rsp_valid === 1'b1) begin
      vectors++;
      if (q_a.size() == 0) begin
        miscompares++;
        $display("FAIL a_rsp_unexpected: got data=%h err=%b at cyc %0d, wanted no response",
                 bus.a_rsp_data, bus.a_rsp_err, cyc);
      end else begin
        xa = q_a.pop_front();
        if (bus.a_rsp_data !== xa.data || bus.a_rsp_err !== xa.err || cyc != xa.due) begin
          miscompares++;
          $display("FAIL a_rsp: got data=%h err=%b cyc=%0d, want data=%h err=%b cyc=%0d",
                   bus.a_rsp_data, bus.a_rsp_err, cyc, xa.data, xa.err, xa.due);
        end
      end
    end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL a_rsp_missing: got no response at cyc %0d, want data=%h err=%b",
               cyc, q_a[0].data, q_a[0].err);
      void'(q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus.b_rsp_valid === 1'b1) begin
      vectors++;
      if (q_b.size() == 0) begin
        miscompares++;
        $display("FAIL b_rsp_unexpected: got data=%h err=%b at cyc %0d, wanted no response",
                 bus.b_rsp_data, bus.b_rsp_err, cyc);
      end else begin
        xb = q_b.pop_front();
        if (bus.b_rsp_data !== xb.data || bus.b_rsp_err !== xb.err || cyc != xb.due) begin
          miscompares++;
          $display("FAIL b_rsp: got data=%h err=%b cyc=%0d, want data=%h err=%b cyc=%0d",
                   bus.b_rsp_data, bus.b_rsp_err, cyc, xb.data, xb.err, xb.due);
        end
      end
    end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL b_rsp_missing: got no response at cyc %0d, want data=%h err=%b",
               cyc, q_b[0].data, q_b[0].err);
      void'(q_b.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drives one cycle of requests and pushes the model's expected responses.
  task automatic drive(input bit av, input logic [63:0] aa,
                       input bit bv, input bit bwe, input logic [1:0] bs,
                       input logic [63:0] ba, input logic [63:0] bd);
    exp_t ea, eb;
    int   nb, off, k;
    @(negedge clk);
    bus.a_valid   = av;
    bus.a_addr    = aa;
    bus.b_valid   = bv;
    bus.b_we      = bwe;
    bus.b_size    = byt_e'(bs);
    bus.b_addr    = ba;
    bus.b_wr_data = bd;
    if (av) begin
      ea.due  = cyc + LAT;
      ea.err  = !in_rng(aa);
      ea.data = ea.err ? 64'd0 : mdl[widx(aa)];
      q_a.push_back(ea);
    end
    if (bv) begin
      nb      = 1 << bs;
      off     = int'(ba[2:0]);
      eb.due  = cyc + LAT;
      eb.err  = !in_rng(ba) || ((off % nb) != 0);
      eb.data = (eb.err || bwe) ? 64'd0 : mdl[widx(ba)];
      if (bwe && !eb.err) begin
        k = widx(ba);
        for (int j = 0; j < 8; j++)
          if (j >= off && j < off + nb) mdl[k][8*j +: 8] = bd[8*(j-off) +: 8];
      end
      q_b.push_back(eb);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 4*LAT + 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      miscompares++;
      $display("FAIL drain_%s: got %0d/%0d responses outstanding, want 0/0",
               tag, q_a.size(), q_b.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.a_ready !== 1'b0) begin miscompares++; $display("FAIL reset_a_ready: got %b want 0", bus.a_ready); end
    vectors++;
    if (bus.b_ready !== 1'b0) begin miscompares++; $display("FAIL reset_b_ready: got %b want 0", bus.b_ready); end
    vectors++;
    if (bus.a_rsp_valid !== 1'b0 || bus.a_rsp_data !== 64'd0 || bus.a_rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_a_rsp: got v=%b d=%h e=%b want 0/0/0", bus.a_rsp_valid, bus.a_rsp_data, bus.a_rsp_err);
    end
    vectors++;
    if (bus.b_rsp_valid !== 1'b0 || bus.b_rsp_data !== 64'd0 || bus.b_rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b_rsp: got v=%b d=%h e=%b want 0/0/0", bus.b_rsp_valid, bus.b_rsp_data, bus.b_rsp_err);
    end
  endtask

  task automatic test_clear();
    int n = 0;
    @(negedge clk);
    rst = 1'b0;
    while (bus.a_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != DEPTH) begin miscompares++; $display("FAIL clear_ready_low_cycles: got %0d want %0d", n, DEPTH); end
    vectors++;
    if (bus.b_ready !== 1'b1) begin miscompares++; $display("FAIL clear_b_ready: got %b want 1", bus.b_ready); end
  endtask

  task automatic test_clear_readback();
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, BASE + 64'(8*i), 1'b1, 1'b0, 2'd3, BASE + 64'(8*(DEPTH-1-i)), 64'd0);
    idle();
    drain("clear_readback");
  endtask

  task automatic test_write_read();
    drive(1'b0, 64'd0, 1'b1, 1'b1, 2'd3, BASE + 64'h10, 64'h1122_3344_5566_7788);
    drive(1'b1, BASE + 64'h10, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
    drive(1'b0, 64'd0, 1'b1, 1'b1, 2'd0, BASE + 64'h13, 64'h0000_0000_0000_00AB);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 2'd3, BASE + 64'h10, 64'd0);
    idle();
    drain("write_read");
    vectors++;
    if (mdl[2] !== 64'h1122_3344_AB66_7788) begin
      miscompares++;
      $display("FAIL byte_merge_model: got %h want 11223344ab667788", mdl[2]);
    end
  endtask

  task automatic test_errors();
    drive(1'b1, 64'h7FFF_FFF8, 1'b1, 1'b1, 2'd2, BASE + 64'h12, 64'hDEAD_BEEF_CAFE_F00D);
    drive(1'b1, BASE + 64'h80, 1'b1, 1'b0, 2'd3, BASE + 64'h10, 64'd0);
    drive(1'b1, BASE + 64'h7F, 1'b1, 1'b0, 2'd1, BASE + 64'h11, 64'd0);
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b1, 2'd3, BASE + 64'h80, 64'h5555_5555_5555_5555);
    drive(1'b0, 64'd0, 1'b1, 1'b1, 2'd3, BASE - 64'h8, 64'h6666_6666_6666_6666);
    drive(1'b1, BASE + 64'h10, 1'b1, 1'b0, 2'd3, BASE + 64'h78, 64'd0);
    idle();
    drain("errors");
  endtask

  task automatic test_rbw();
    drive(1'b1, BASE + 64'h20, 1'b1, 1'b1, 2'd3, BASE + 64'h20, 64'hCAFE_F00D_1234_5678);
    drive(1'b1, BASE + 64'h20, 1'b1, 1'b0, 2'd3, BASE + 64'h20, 64'd0);
    idle();
    drain("rbw");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++)
      drive(1'b1, BASE + 64'(8*i), 1'b1, 1'b1, 2'd3, BASE + 64'(8*(i+5)), {$urandom, $urandom});
    for (int i = 0; i < 40; i++)
      drive(1'($urandom_range(0, 1)), BASE + 64'($urandom_range(0, 8*DEPTH + 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            BASE + 64'($urandom_range(0, 8*DEPTH + 15)), {$urandom, $urandom});
    idle();
    drain("back_to_back");
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    drive(1'b0, 64'd0, 1'b1, 1'b1, 2'd3, BASE + 64'h00, 64'hA5A5_0000_0000_0001);
    drive(1'b0, 64'd0, 1'b1, 1'b1, 2'd3, BASE + 64'h38, 64'hA5A5_0000_0000_0007);
    drive(1'b0, 64'd0, 1'b1, 1'b1, 2'd3, BASE + 64'h40, 64'hA5A5_0000_0000_0008);
    drive(1'b0, 64'd0, 1'b1, 1'b1, 2'd3, BASE + 64'h78, 64'hA5A5_0000_0000_000F);
    idle();
    drain("pre_reset");
    for (int i = 0; i < 3; i++)
      drive(1'b1, BASE + 64'(8*i), 1'b1, 1'b0, 2'd3, BASE + 64'(8*i), 64'd0);
    @(posedge clk);
    #2;
    vectors++;
    if (bus.a_rsp_valid !== 1'b1 || bus.b_rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_valids: got a=%b b=%b want 1/1", bus.a_rsp_valid, bus.b_rsp_valid);
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.a_rsp_valid !== 1'b0 || bus.b_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_valid_drop: got a=%b b=%b want 0/0", bus.a_rsp_valid, bus.b_rsp_valid);
    end
    q_a.delete();
    q_b.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_clear_ready: got a=%b b=%b want 0/0", bus.a_ready, bus.b_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    while (bus.a_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != DEPTH) begin miscompares++; $display("FAIL reclear_ready_low_cycles: got %0d want %0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) mdl[i] = 64'd0;
    drive(1'b1, BASE + 64'h00, 1'b1, 1'b0, 2'd3, BASE + 64'h38, 64'd0);
    drive(1'b1, BASE + 64'h40, 1'b1, 1'b0, 2'd3, BASE + 64'h78, 64'd0);
    drive(1'b1, BASE + 64'h10, 1'b1, 1'b0, 2'd3, BASE + 64'h20, 64'd0);
    idle();
    drain("reclear_readback");
  endtask

  initial begin
    bus.a_valid   = 1'b0;
    bus.a_addr    = 64'd0;
    bus.b_valid   = 1'b0;
    bus.b_we      = 1'b0;
    bus.b_size    = BYT_1;
    bus.b_addr    = 64'd0;
    bus.b_wr_data = 64'd0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 64'd0;
    test_reset();
    test_clear();
    test_clear_readback();
    test_write_read();
    test_errors();
    test_rbw();
    test_back_to_back();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
